// File: rtl/rv_pkg.sv
// Shared RV32I execute-stage definitions: datapath width, ALU opcodes and
// operand-select encodings.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_BEQ  = 4'd10,
        ALU_BNE  = 4'd11,
        ALU_BLT  = 4'd12,
        ALU_BGE  = 4'd13,
        ALU_BLTU = 4'd14,
        ALU_BGEU = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCA_REG  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2,
        SRCA_JALR = 2'd3
    } srca_sel_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2,
        SRCB_ZERO = 2'd3
    } srcb_sel_t;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX-side inputs and E/M-side outputs of the execute stage, bundled as one
// interface; the stage itself uses the slave modport.
interface execute_stage_if;
    import rv_pkg::*;

    logic [2:0]      strCtrlE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            MemtoRegE;
    logic            PCBranchE;
    logic [3:0]      ALUopE;
    logic [1:0]      SrcASelE;
    logic [1:0]      SrcBSelE;
    logic [XLEN-1:0] immE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] r1E;
    logic [XLEN-1:0] r2E;
    logic [4:0]      rdE;

    logic [2:0]      strCtrlM;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            MemtoRegM;
    logic [XLEN-1:0] ALUoutM;
    logic [XLEN-1:0] PCplusImmM;
    logic [4:0]      rdM;
    logic [XLEN-1:0] r2M;
    logic            PCsrcE;

    modport slave (
        input  strCtrlE, RegWriteE, MemWriteE, MemtoRegE, PCBranchE, ALUopE,
               SrcASelE, SrcBSelE, immE, PCE, r1E, r2E, rdE,
        output strCtrlM, RegWriteM, MemWriteM, MemtoRegM, ALUoutM, PCplusImmM,
               rdM, r2M, PCsrcE
    );

    modport master (
        output strCtrlE, RegWriteE, MemWriteE, MemtoRegE, PCBranchE, ALUopE,
               SrcASelE, SrcBSelE, immE, PCE, r1E, r2E, rdE,
        input  strCtrlM, RegWriteM, MemWriteM, MemtoRegM, ALUoutM, PCplusImmM,
               rdM, r2M, PCsrcE
    );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU; compare ops return 0/1 and also drive cond, every
// other op reports cond=1 so unconditional jumps are always taken.
module alu
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result,
    output logic            cond
);

    logic eq;
    logic lt_s;
    logic lt_u;

    always_comb begin
        eq   = (a == b);
        lt_s = ($signed(a) < $signed(b));
        lt_u = (a < b);
    end

    always_comb begin
        result = '0;
        cond   = 1'b1;
        case (alu_op_t'(op))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            ALU_BEQ:  cond = eq;
            ALU_BNE:  cond = ~eq;
            ALU_BLT:  cond = lt_s;
            ALU_BGE:  cond = ~lt_s;
            ALU_BLTU: cond = lt_u;
            ALU_BGEU: cond = ~lt_u;
            default:  result = '0;
        endcase
        if (op >= ALU_BEQ)
            result = {{(XLEN-1){1'b0}}, cond};
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand muxes, ALU, branch/jump target adder, redirect
// decision and the E/M pipeline register.
module execute_stage
    import rv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    execute_stage_if.slave    bus
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] alu_result;
    logic            alu_cond;

    always_comb begin
        src_a = '0;
        case (srca_sel_t'(bus.SrcASelE))
            SRCA_REG:  src_a = bus.r1E;
            SRCA_PC:   src_a = bus.PCE;
            SRCA_ZERO: src_a = '0;
            SRCA_JALR: src_a = bus.PCE;
            default:   src_a = '0;
        endcase
    end

    always_comb begin
        src_b = '0;
        case (srcb_sel_t'(bus.SrcBSelE))
            SRCB_REG:  src_b = bus.r2E;
            SRCB_IMM:  src_b = bus.immE;
            SRCB_FOUR: src_b = 32'd4;
            SRCB_ZERO: src_b = '0;
            default:   src_b = '0;
        endcase
    end

    // JALR computes its target from rs1 while the ALU still forms PC+4 for the link.
    always_comb begin
        if (bus.SrcASelE == SRCA_JALR) begin
            target    = bus.r1E + bus.immE;
            target[0] = 1'b0;
        end else begin
            target = bus.PCE + bus.immE;
        end
    end

    alu u_alu (
        .a      (src_a),
        .b      (src_b),
        .op     (bus.ALUopE),
        .result (alu_result),
        .cond   (alu_cond)
    );

    assign bus.PCsrcE = bus.PCBranchE & alu_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.strCtrlM   <= '0;
            bus.RegWriteM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.MemtoRegM  <= 1'b0;
            bus.ALUoutM    <= '0;
            bus.PCplusImmM <= '0;
            bus.rdM        <= '0;
            bus.r2M        <= '0;
        end else begin
            bus.strCtrlM   <= bus.strCtrlE;
            bus.RegWriteM  <= bus.RegWriteE;
            bus.MemWriteM  <= bus.MemWriteE;
            bus.MemtoRegM  <= bus.MemtoRegE;
            bus.ALUoutM    <= alu_result;
            bus.PCplusImmM <= target;
            bus.rdM        <= bus.rdE;
            bus.r2M        <= bus.r2E;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a behavioural RV32I execute model checked
// every cycle, plus hand-computed literal expectations.
module tb_execute_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    execute_stage_if bus ();

    execute_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_alu(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        int unsigned sh;
        logic [31:0] all_ones;
        sh = int'(b[4:0]);
        all_ones = 32'hFFFF_FFFF;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return (a >> sh) | (a[31] ? ~(all_ones >> sh) : 32'd0);
            4'd8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return (a == b) ? 32'd1 : 32'd0;
            4'd11: return (a != b) ? 32'd1 : 32'd0;
            4'd12: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd13: return (int'(a) >= int'(b)) ? 32'd1 : 32'd0;
            4'd14: return (a < b) ? 32'd1 : 32'd0;
            default: return (a >= b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_a();
        case (bus.SrcASelE)
            2'd0:    return bus.r1E;
            2'd2:    return 32'd0;
            default: return bus.PCE;
        endcase
    endfunction

    function automatic logic [31:0] model_b();
        case (bus.SrcBSelE)
            2'd0:    return bus.r2E;
            2'd1:    return bus.immE;
            2'd2:    return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_target();
        if (bus.SrcASelE == 2'd3) return (bus.r1E + bus.immE) & 32'hFFFF_FFFE;
        return bus.PCE + bus.immE;
    endfunction

    function automatic logic model_pcsrc();
        logic [31:0] r;
        r = model_alu(bus.ALUopE, model_a(), model_b());
        return bus.PCBranchE & ((bus.ALUopE < 4'd10) ? 1'b1 : r[0]);
    endfunction

    // Expected E/M register contents
    logic [2:0]  exp_str;
    logic        exp_rw, exp_mw, exp_m2r;
    logic [31:0] exp_alu, exp_tgt, exp_r2;
    logic [4:0]  exp_rd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_str <= 3'd0; exp_rw <= 1'b0; exp_mw <= 1'b0; exp_m2r <= 1'b0;
            exp_alu <= 32'd0; exp_tgt <= 32'd0; exp_r2 <= 32'd0; exp_rd <= 5'd0;
        end else begin
            exp_str <= bus.strCtrlE; exp_rw <= bus.RegWriteE;
            exp_mw  <= bus.MemWriteE; exp_m2r <= bus.MemtoRegE;
            exp_alu <= model_alu(bus.ALUopE, model_a(), model_b());
            exp_tgt <= model_target();
            exp_r2  <= bus.r2E; exp_rd <= bus.rdE;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("PCsrcE",     {31'd0, bus.PCsrcE},    {31'd0, model_pcsrc()});
        chk("ALUoutM",    bus.ALUoutM,            exp_alu);
        chk("PCplusImmM", bus.PCplusImmM,         exp_tgt);
        chk("r2M",        bus.r2M,                exp_r2);
        chk("rdM",        {27'd0, bus.rdM},       {27'd0, exp_rd});
        chk("strCtrlM",   {29'd0, bus.strCtrlM},  {29'd0, exp_str});
        chk("ctrlM",      {29'd0, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM},
                          {29'd0, exp_rw, exp_mw, exp_m2r});
    end

    task automatic set_vec(input logic [3:0] op, input logic [1:0] asel, input logic [1:0] bsel,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                           input logic [31:0] pc, input logic br, input logic rw,
                           input logic mw, input logic m2r, input logic [2:0] str,
                           input logic [4:0] rd);
        bus.ALUopE = op; bus.SrcASelE = asel; bus.SrcBSelE = bsel;
        bus.r1E = r1; bus.r2E = r2; bus.immE = imm; bus.PCE = pc;
        bus.PCBranchE = br; bus.RegWriteE = rw; bus.MemWriteE = mw;
        bus.MemtoRegE = m2r; bus.strCtrlE = str; bus.rdE = rd;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_vec(4'd0, 2'd0, 2'd1, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0010,
                32'h0000_1000, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 5'd17);
        #1 rst = 1'b1;
        #2;
        chk("rst_alu", bus.ALUoutM, 32'd0);
        chk("rst_tgt", bus.PCplusImmM, 32'd0);
        chk("rst_ctl", {bus.rdM, bus.strCtrlM, bus.RegWriteM, bus.MemWriteM, bus.MemtoRegM}, 32'd0);
        chk("rst_r2",  bus.r2M, 32'd0);
        next_edge();
        rst = 1'b0;

        // ADD immediate
        set_vec(4'd0, 2'd0, 2'd1, 32'd5, 32'd0, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 5'd3);
        #1 chk("add_pcsrc", {31'd0, bus.PCsrcE}, 32'd0);
        next_edge();
        chk("add_alu", bus.ALUoutM, 32'd12);
        chk("add_rd",  {27'd0, bus.rdM}, 32'd3);
        chk("add_rw",  {31'd0, bus.RegWriteM}, 32'd1);

        set_vec(4'd7, 2'd0, 2'd0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd4);
        next_edge();
        chk("sra_alu", bus.ALUoutM, 32'hF800_0000);

        set_vec(4'd1, 2'd0, 2'd0, 32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd5);
        next_edge();
        chk("sub_alu", bus.ALUoutM, 32'hFFFF_FFFF);

        // Taken BEQ
        set_vec(4'd10, 2'd0, 2'd0, 32'd9, 32'd9, 32'h20, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        #1 chk("beq_pcsrc", {31'd0, bus.PCsrcE}, 32'd1);
        next_edge();
        chk("beq_tgt", bus.PCplusImmM, 32'h120);

        set_vec(4'd12, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        #1 chk("blt_pcsrc", {31'd0, bus.PCsrcE}, 32'd1);
        next_edge();
        set_vec(4'd14, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        #1 chk("bltu_pcsrc", {31'd0, bus.PCsrcE}, 32'd0);
        next_edge();

        // JAL then JALR
        set_vec(4'd0, 2'd1, 2'd2, 32'd0, 32'd0, 32'd8, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd1);
        #1 chk("jal_pcsrc", {31'd0, bus.PCsrcE}, 32'd1);
        next_edge();
        chk("jal_link", bus.ALUoutM, 32'h44);
        chk("jal_tgt",  bus.PCplusImmM, 32'h48);

        set_vec(4'd0, 2'd3, 2'd2, 32'h201, 32'd0, 32'd0, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd1);
        #1 chk("jalr_pcsrc", {31'd0, bus.PCsrcE}, 32'd1);
        next_edge();
        chk("jalr_tgt",  bus.PCplusImmM, 32'h200);
        chk("jalr_link", bus.ALUoutM, 32'h84);

        // Remaining ops and selects, checked by the model only
        set_vec(4'd2, 2'd0, 2'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd6); next_edge();
        set_vec(4'd3, 2'd0, 2'd1, 32'h0000_00F0, 32'd0, 32'h0000_0F0F, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd7); next_edge();
        set_vec(4'd4, 2'd0, 2'd0, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd8); next_edge();
        set_vec(4'd5, 2'd0, 2'd0, 32'h0000_0003, 32'h0000_0021, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd9); next_edge();
        set_vec(4'd6, 2'd0, 2'd0, 32'h8000_0000, 32'd31, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd10); next_edge();
        set_vec(4'd7, 2'd0, 2'd0, 32'h7000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd11); next_edge();
        set_vec(4'd8, 2'd0, 2'd0, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd12); next_edge();
        set_vec(4'd9, 2'd0, 2'd0, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd13); next_edge();
        set_vec(4'd11, 2'd0, 2'd0, 32'd9, 32'd9, 32'h10, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0); next_edge();
        set_vec(4'd13, 2'd0, 2'd0, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFF0, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0); next_edge();
        set_vec(4'd15, 2'd0, 2'd0, 32'd5, 32'hFFFF_FFFB, 32'h8, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0); next_edge();
        set_vec(4'd0, 2'd2, 2'd1, 32'hFFFF_FFFF, 32'd0, 32'hABCD_E000, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd14); next_edge();
        set_vec(4'd0, 2'd0, 2'd3, 32'h1357_9BDF, 32'd0, 32'd0, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd15); next_edge();
        set_vec(4'd0, 2'd0, 2'd1, 32'h1000, 32'hCAFE_F00D, 32'h8, 32'h404, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 5'd0); next_edge();
        chk("sw_r2", bus.r2M, 32'hCAFE_F00D);
        set_vec(4'd0, 2'd0, 2'd1, 32'h1000, 32'd0, 32'h4, 32'h408, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 5'd20); next_edge();
        set_vec(4'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0); next_edge();

        // Reset mid-operation: outputs clear at once and the in-flight op is lost
        set_vec(4'd0, 2'd1, 2'd2, 32'd0, 32'd0, 32'd8, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd1); next_edge();
        set_vec(4'd0, 2'd0, 2'd1, 32'd1, 32'd1, 32'd1, 32'h50, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 5'd2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_alu", bus.ALUoutM, 32'd0);
        chk("midrst_tgt", bus.PCplusImmM, 32'd0);
        chk("midrst_ctl", {27'd0, bus.rdM}, 32'd0);
        next_edge();
        rst = 1'b0;
        chk("midrst_drop", bus.ALUoutM, 32'd0);
        next_edge();
        chk("post_rst_alu", bus.ALUoutM, 32'd2);
        next_edge();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
